// File: rtl/control_operacion.sv
// Sequencing controller for the calculator's signed-magnitude arithmetic unit.
// Add/sub go through the external datapath; multiply and divide iterate here.
module control_operacion (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [9:0]  num1,
  input  logic [9:0]  num2,
  input  logic        sig1,
  input  logic [1:0]  oper,
  output logic [9:0]  alu_num1,
  output logic [9:0]  alu_num2,
  output logic        alu_sig1,
  output logic [1:0]  alu_oper,
  input  logic [19:0] alu_resultado,
  input  logic        alu_signo,
  output logic [19:0] resultado,
  output logic        signo_resultado,
  output logic        busy,
  output logic        done,
  output logic        error
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_MUL   = 3'd2,
    S_DIV   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [3:0] LAST_ITER = 4'd9;

  state_t state_q, state_d;

  logic [9:0]  alu_num1_q, alu_num1_d;
  logic [9:0]  alu_num2_q, alu_num2_d;
  logic        alu_sig1_q, alu_sig1_d;
  logic [1:0]  alu_oper_q, alu_oper_d;
  logic [19:0] resultado_q, resultado_d;
  logic        signo_q, signo_d;
  logic        error_q, error_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [19:0] mcand_q, mcand_d;
  logic [9:0]  mplier_q, mplier_d;
  logic [19:0] acc_q, acc_d;
  logic [9:0]  dvd_q, dvd_d;
  logic [9:0]  rem_q, rem_d;
  logic [9:0]  quo_q, quo_d;

  logic        accept;
  logic        last_iter;
  logic [19:0] acc_next;
  logic [10:0] trial;
  logic        q_bit;
  logic [9:0]  rem_next;
  logic [9:0]  quo_next;

  assign accept    = (state_q == S_IDLE) && start;
  assign last_iter = (cnt_q == LAST_ITER);

  // Multiply step: multiplicand is pre-shifted each cycle, so it already
  // carries the iteration-index weight when added.
  assign acc_next = acc_q + (mplier_q[0] ? mcand_q : 20'd0);

  // Restoring divide step: bring down the next dividend bit (MSB first).
  assign trial    = {rem_q, dvd_q[9]};
  assign q_bit    = (trial >= {1'b0, alu_num2_q});
  assign rem_next = q_bit ? 10'(trial - {1'b0, alu_num2_q}) : trial[9:0];
  assign quo_next = {quo_q[8:0], q_bit};

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          case (oper)
            2'd0, 2'd1: state_d = S_ISSUE;
            2'd2:       state_d = S_MUL;
            default:    state_d = (num2 == 10'd0) ? S_DONE : S_DIV;
          endcase
        end
      end
      S_ISSUE: state_d = S_DONE;
      S_MUL:   state_d = last_iter ? S_DONE : S_MUL;
      S_DIV:   state_d = last_iter ? S_DONE : S_DIV;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy = (state_q != S_IDLE);
    done = (state_q == S_DONE);
  end

  // Datapath next-value logic
  always_comb begin
    alu_num1_d  = alu_num1_q;
    alu_num2_d  = alu_num2_q;
    alu_sig1_d  = alu_sig1_q;
    alu_oper_d  = alu_oper_q;
    resultado_d = resultado_q;
    signo_d     = signo_q;
    error_d     = error_q;
    cnt_d       = cnt_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    acc_d       = acc_q;
    dvd_d       = dvd_q;
    rem_d       = rem_q;
    quo_d       = quo_q;

    if (accept) begin
      alu_num1_d = num1;
      alu_num2_d = num2;
      alu_sig1_d = sig1;
      alu_oper_d = oper[1] ? 2'd0 : oper;
      error_d    = 1'b0;
      cnt_d      = 4'd0;
      mcand_d    = {10'd0, num1};
      mplier_d   = num2;
      acc_d      = 20'd0;
      dvd_d      = num1;
      rem_d      = 10'd0;
      quo_d      = 10'd0;
      if (oper == 2'd3 && num2 == 10'd0) begin
        resultado_d = 20'd0;
        signo_d     = 1'b0;
        error_d     = 1'b1;
      end
    end

    case (state_q)
      S_ISSUE: begin
        resultado_d = alu_resultado;
        signo_d     = alu_signo;
      end
      S_MUL: begin
        acc_d    = acc_next;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 4'd1;
        if (last_iter) begin
          resultado_d = acc_next;
          signo_d     = alu_sig1_q && (acc_next != 20'd0);
        end
      end
      S_DIV: begin
        rem_d = rem_next;
        quo_d = quo_next;
        dvd_d = dvd_q << 1;
        cnt_d = cnt_q + 4'd1;
        if (last_iter) begin
          resultado_d = {rem_next, quo_next};
          signo_d     = alu_sig1_q && (quo_next != 10'd0);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      alu_num1_q  <= '0;
      alu_num2_q  <= '0;
      alu_sig1_q  <= 1'b0;
      alu_oper_q  <= '0;
      resultado_q <= '0;
      signo_q     <= 1'b0;
      error_q     <= 1'b0;
      cnt_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      dvd_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
    end else begin
      alu_num1_q  <= alu_num1_d;
      alu_num2_q  <= alu_num2_d;
      alu_sig1_q  <= alu_sig1_d;
      alu_oper_q  <= alu_oper_d;
      resultado_q <= resultado_d;
      signo_q     <= signo_d;
      error_q     <= error_d;
      cnt_q       <= cnt_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      acc_q       <= acc_d;
      dvd_q       <= dvd_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
    end
  end

  assign alu_num1        = alu_num1_q;
  assign alu_num2        = alu_num2_q;
  assign alu_sig1        = alu_sig1_q;
  assign alu_oper        = alu_oper_q;
  assign resultado       = resultado_q;
  assign signo_resultado = signo_q;
  assign error           = error_q;

endmodule

// File: tb/tb_control_operacion.sv
// Directed bench for control_operacion with a behavioural add/sub datapath.
module tb_control_operacion;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [9:0]  num1 = '0, num2 = '0;
  logic        sig1 = 1'b0;
  logic [1:0]  oper = '0;
  logic [9:0]  alu_num1, alu_num2;
  logic        alu_sig1;
  logic [1:0]  alu_oper;
  logic [19:0] alu_resultado;
  logic        alu_signo;
  logic [19:0] resultado;
  logic        signo_resultado, busy, done, error;

  int checks = 0;
  int errs   = 0;

  always #5 clk = ~clk;

  control_operacion dut (
    .clk(clk), .rst(rst), .start(start), .num1(num1), .num2(num2),
    .sig1(sig1), .oper(oper), .alu_num1(alu_num1), .alu_num2(alu_num2),
    .alu_sig1(alu_sig1), .alu_oper(alu_oper), .alu_resultado(alu_resultado),
    .alu_signo(alu_signo), .resultado(resultado),
    .signo_resultado(signo_resultado), .busy(busy), .done(done), .error(error)
  );

  // Signed-magnitude add/sub datapath; zero for opcodes it does not implement.
  always_comb begin
    int v1, r;
    v1 = alu_sig1 ? -int'(alu_num1) : int'(alu_num1);
    r  = 0;
    if (alu_oper == 2'd0) r = v1 + int'(alu_num2);
    if (alu_oper == 2'd1) r = v1 - int'(alu_num2);
    alu_signo     = (r < 0);
    alu_resultado = 20'((r < 0) ? -r : r);
  end

  // Drive one start pulse; returns in cycle k+1 (1 time unit after edge k).
  task automatic do_start(input logic [1:0] op, input logic s,
                          input logic [9:0] a, input logic [9:0] b);
    @(negedge clk);
    start = 1'b1; oper = op; sig1 = s; num1 = a; num2 = b;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Latency in cycles after the accept edge at which done is seen.
  task automatic wait_done(output int lat);
    lat = 1;
    while (done !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, error, signo_resultado} !== 4'b0 || resultado !== 20'd0 ||
        alu_num1 !== 10'd0 || alu_num2 !== 10'd0 || alu_oper !== 2'd0 || alu_sig1 !== 1'b0) begin
      $display("FAIL reset: busy=%b done=%b err=%b res=%0d alu_num1=%0d exp all 0",
               busy, done, error, resultado, alu_num1);
      errs++;
    end
    rst = 1'b0;
  endtask

  task automatic test_add;
    int lat;
    do_start(2'd0, 1'b0, 10'd300, 10'd200);
    checks++;
    if (busy !== 1'b1 || alu_num1 !== 10'd300 || alu_num2 !== 10'd200 || alu_oper !== 2'd0) begin
      $display("FAIL add_issue: busy=%b alu_num1=%0d alu_num2=%0d alu_oper=%0d exp 1/300/200/0",
               busy, alu_num1, alu_num2, alu_oper);
      errs++;
    end
    wait_done(lat);
    checks++;
    if (lat !== 2 || resultado !== 20'd500 || signo_resultado !== 1'b0 || error !== 1'b0) begin
      $display("FAIL add: lat=%0d res=%0d sgn=%b err=%b exp 2/500/0/0", lat, resultado, signo_resultado, error);
      errs++;
    end
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      $display("FAIL add_after: busy=%b done=%b exp 0/0", busy, done);
      errs++;
    end
  endtask

  task automatic test_sub;
    int lat;
    do_start(2'd1, 1'b0, 10'd100, 10'd250);
    checks++;
    if (alu_oper !== 2'd1) begin
      $display("FAIL sub_oper: alu_oper=%0d exp 1", alu_oper);
      errs++;
    end
    wait_done(lat);
    checks++;
    if (lat !== 2 || resultado !== 20'd150 || signo_resultado !== 1'b1) begin
      $display("FAIL sub: lat=%0d res=%0d sgn=%b exp 2/150/1", lat, resultado, signo_resultado);
      errs++;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_mul;
    int lat;
    do_start(2'd2, 1'b1, 10'd1023, 10'd1023);
    checks++;
    if (busy !== 1'b1 || alu_oper !== 2'd0 || resultado !== 20'd150) begin
      $display("FAIL mul_start: busy=%b alu_oper=%0d res=%0d exp 1/0/150", busy, alu_oper, resultado);
      errs++;
    end
    wait_done(lat);
    checks++;
    if (lat !== 11 || resultado !== 20'd1046529 || signo_resultado !== 1'b1) begin
      $display("FAIL mul: lat=%0d res=%0d sgn=%b exp 11/1046529/1", lat, resultado, signo_resultado);
      errs++;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_mul_zero;
    int lat;
    do_start(2'd2, 1'b1, 10'd0, 10'd5);
    wait_done(lat);
    checks++;
    if (lat !== 11 || resultado !== 20'd0 || signo_resultado !== 1'b0) begin
      $display("FAIL mul_zero: lat=%0d res=%0d sgn=%b exp 11/0/0", lat, resultado, signo_resultado);
      errs++;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_div;
    int lat;
    do_start(2'd3, 1'b0, 10'd1000, 10'd7);
    wait_done(lat);
    checks++;
    if (lat !== 11 || resultado !== 20'd6286 || signo_resultado !== 1'b0 || error !== 1'b0) begin
      $display("FAIL div: lat=%0d res=%0d sgn=%b err=%b exp 11/6286/0/0",
               lat, resultado, signo_resultado, error);
      errs++;
    end
    @(posedge clk); #1;
    // Negative dividend: 37 / 5 -> quotient 7, remainder 2, sign kept.
    do_start(2'd3, 1'b1, 10'd37, 10'd5);
    wait_done(lat);
    checks++;
    if (resultado !== 20'd2055 || signo_resultado !== 1'b1) begin
      $display("FAIL div_neg: res=%0d sgn=%b exp 2055/1", resultado, signo_resultado);
      errs++;
    end
    @(posedge clk); #1;
    // Zero quotient forces positive sign: 3 / 9 -> quotient 0, remainder 3.
    do_start(2'd3, 1'b1, 10'd3, 10'd9);
    wait_done(lat);
    checks++;
    if (resultado !== 20'd3072 || signo_resultado !== 1'b0) begin
      $display("FAIL div_zero_quot: res=%0d sgn=%b exp 3072/0", resultado, signo_resultado);
      errs++;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_div_zero;
    int lat;
    do_start(2'd3, 1'b1, 10'd55, 10'd0);
    wait_done(lat);
    checks++;
    if (lat !== 1 || error !== 1'b1 || resultado !== 20'd0 || signo_resultado !== 1'b0) begin
      $display("FAIL div_by_zero: lat=%0d err=%b res=%0d sgn=%b exp 1/1/0/0",
               lat, error, resultado, signo_resultado);
      errs++;
    end
    @(posedge clk); #1;
    checks++;
    if (error !== 1'b1 || busy !== 1'b0) begin
      $display("FAIL div_by_zero_hold: err=%b busy=%b exp 1/0", error, busy);
      errs++;
    end
  endtask

  task automatic test_start_ignored;
    int lat;
    lat = 0;
    do_start(2'd2, 1'b0, 10'd12, 10'd13);
    checks++;
    if (error !== 1'b0) begin
      $display("FAIL start_clears_err: err=%b exp 0", error);
      errs++;
    end
    for (int c = 1; c <= 15 && lat == 0; c++) begin
      if (c == 3) begin start = 1'b1; oper = 2'd0; num1 = 10'd1; num2 = 10'd1; end
      if (c == 4) start = 1'b0;
      if (done === 1'b1) lat = c;
      else begin @(posedge clk); #1; end
    end
    checks++;
    if (lat !== 11 || resultado !== 20'd156 || alu_num1 !== 10'd12) begin
      $display("FAIL start_ignored: lat=%0d res=%0d alu_num1=%0d exp 11/156/12", lat, resultado, alu_num1);
      errs++;
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || alu_num1 !== 10'd12) begin
      $display("FAIL start_not_queued: busy=%b alu_num1=%0d exp 0/12", busy, alu_num1);
      errs++;
    end
  endtask

  task automatic test_reset_mid;
    int seen;
    seen = 0;
    do_start(2'd3, 1'b1, 10'd1000, 10'd7);
    repeat (4) begin @(posedge clk); #1; if (done === 1'b1) seen++; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || resultado !== 20'd0 || alu_num1 !== 10'd0 ||
        alu_num2 !== 10'd0 || alu_sig1 !== 1'b0 || alu_oper !== 2'd0 ||
        signo_resultado !== 1'b0 || error !== 1'b0) begin
      $display("FAIL reset_mid: busy=%b done=%b res=%0d alu_num1=%0d err=%b exp all 0",
               busy, done, resultado, alu_num1, error);
      errs++;
    end
    repeat (12) begin @(posedge clk); #1; if (done === 1'b1 || busy === 1'b1) seen++; end
    checks++;
    if (seen !== 0) begin
      $display("FAIL reset_mid_no_done: activity=%0d exp 0", seen);
      errs++;
    end
  endtask

  task automatic test_after_reset;
    int lat;
    do_start(2'd0, 1'b1, 10'd7, 10'd8);
    wait_done(lat);
    checks++;
    if (lat !== 2 || resultado !== 20'd1 || signo_resultado !== 1'b0) begin
      $display("FAIL after_reset: lat=%0d res=%0d sgn=%b exp 2/1/0", lat, resultado, signo_resultado);
      errs++;
    end
    @(posedge clk); #1;
  endtask

  // start held high: next operation accepted at the edge ending the first IDLE cycle.
  task automatic test_back_to_back;
    int lat;
    do_start(2'd0, 1'b0, 10'd4, 10'd5);
    start = 1'b1;
    wait_done(lat);
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || resultado !== 20'd9) begin
      $display("FAIL b2b_idle: busy=%b res=%0d exp 0/9", busy, resultado);
      errs++;
    end
    oper = 2'd1; num1 = 10'd20; num2 = 10'd6;
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || alu_num1 !== 10'd20 || alu_oper !== 2'd1) begin
      $display("FAIL b2b_retrigger: busy=%b alu_num1=%0d alu_oper=%0d exp 1/20/1", busy, alu_num1, alu_oper);
      errs++;
    end
    wait_done(lat);
    checks++;
    if (lat !== 2 || resultado !== 20'd14) begin
      $display("FAIL b2b_result: lat=%0d res=%0d exp 2/14", lat, resultado);
      errs++;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset;
    test_add;
    test_sub;
    test_mul;
    test_mul_zero;
    test_div;
    test_div_zero;
    test_start_ignored;
    test_div_zero;
    test_reset_mid;
    test_after_reset;
    test_back_to_back;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
    $finish;
  end

endmodule
